// File: rtl/sync_pulse_gen.sv
// sync_pulse_gen
// Multi-channel start-of-transfer to sync-pulse generator. Each channel turns
// a qualified trigger into a pulse with programmable delay D and extra width W.
// The pulse is active for cycles t+D .. t+D+W. A trigger on a busy channel is
// either a retrigger or a drop, and drops are counted in a saturating counter.
module sync_pulse_gen #(
    parameter int                NUM_CH   = 2,
    parameter int                CNT_W    = 16,
    parameter int                EDGE_DET = 0,
    parameter logic [NUM_CH-1:0] OUT_POL  = {NUM_CH{1'b1}},
    parameter int                MISS_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    retrig_en,
    input  logic [NUM_CH-1:0]       trig,
    input  logic [NUM_CH*CNT_W-1:0] delay_cfg,
    input  logic [NUM_CH*CNT_W-1:0] width_cfg,
    output logic [NUM_CH-1:0]       sync_out,
    output logic [NUM_CH-1:0]       busy,
    output logic [MISS_W-1:0]       miss_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [CNT_W-1:0]  DLY_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]    WID_ONE  = (CNT_W + 1)'(1);
    localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

    logic [NUM_CH-1:0] trig_d;
    logic [NUM_CH-1:0] qual;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] act;
    logic [NUM_CH-1:0] busy_v;

    // In edge mode only a rising edge of trig counts; otherwise a held level
    // retriggers every cycle.
    assign qual   = (EDGE_DET != 0) ? (trig & ~trig_d) : trig;
    assign accept = qual & {NUM_CH{enable}} & (~busy_v | {NUM_CH{retrig_en}});
    assign drop   = qual & {NUM_CH{enable}} & busy_v & {NUM_CH{~retrig_en}};

    assign busy     = busy_v;
    assign sync_out = ~(act ^ OUT_POL);

    // Trigger history for edge detection keeps updating even while disabled,
    // so a trigger already high when enable rises is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_d <= '0;
        end else begin
            trig_d <= trig;
        end
    end

    // Count cycles with at least one dropped trigger, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt <= '0;
        end else if ((|drop) && (miss_cnt != {MISS_W{1'b1}})) begin
            miss_cnt <= miss_cnt + MISS_ONE;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] d_in;
        logic [CNT_W-1:0] w_in;
        logic [1:0]       state;
        logic [CNT_W-1:0] dly_cnt;
        logic [CNT_W-1:0] w_lat;
        logic [CNT_W:0]   wid_cnt;

        assign d_in = delay_cfg[i*CNT_W +: CNT_W];
        assign w_in = width_cfg[i*CNT_W +: CNT_W];

        assign busy_v[i] = (state != ST_IDLE);

        // D=0 fires combinationally in the trigger cycle; everything else
        // comes from the registered ACTIVE state. Reset forces the inactive level.
        assign act[i] = (state == ST_ACTIVE) |
                        (accept[i] & (d_in == '0) & ~rst);

        // dly_cnt holds remaining DELAY cycles, wid_cnt remaining ACTIVE cycles
        // (one bit wider so W+1 never overflows when W is all-ones).
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state   <= ST_IDLE;
                dly_cnt <= '0;
                w_lat   <= '0;
                wid_cnt <= '0;
            end else if (accept[i]) begin
                if ((state == ST_ACTIVE) || (d_in == '0)) begin
                    if (w_in == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        state   <= ST_ACTIVE;
                        wid_cnt <= {1'b0, w_in};
                    end
                end else if (d_in == DLY_ONE) begin
                    state   <= ST_ACTIVE;
                    wid_cnt <= {1'b0, w_in} + WID_ONE;
                end else begin
                    state   <= ST_DELAY;
                    dly_cnt <= d_in - DLY_ONE;
                    w_lat   <= w_in;
                end
            end else begin
                case (state)
                    ST_DELAY: begin
                        if (dly_cnt == DLY_ONE) begin
                            state   <= ST_ACTIVE;
                            wid_cnt <= {1'b0, w_lat} + WID_ONE;
                        end else begin
                            dly_cnt <= dly_cnt - DLY_ONE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (wid_cnt == WID_ONE) begin
                            state <= ST_IDLE;
                        end else begin
                            wid_cnt <= wid_cnt - WID_ONE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sync_pulse_gen.sv
// tb_sync_pulse_gen
// Directed bench: a 4-channel level-triggered instance with mixed polarity and
// a small miss counter, plus a 1-channel edge-triggered instance.
module tb_sync_pulse_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic retrig_en = 1'b0;

    logic [3:0]  a_trig = '0;
    logic [31:0] a_delay = '0;
    logic [31:0] a_width = '0;
    logic [3:0]  a_sync;
    logic [3:0]  a_busy;
    logic [3:0]  a_miss;

    logic [0:0]  b_trig = '0;
    logic [7:0]  b_delay = '0;
    logic [7:0]  b_width = '0;
    logic [0:0]  b_sync;
    logic [0:0]  b_busy;
    logic [7:0]  b_miss;

    int errors = 0;
    int checks = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    sync_pulse_gen #(
        .NUM_CH(4), .CNT_W(8), .EDGE_DET(0), .OUT_POL(4'b0101), .MISS_W(4)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .retrig_en(retrig_en),
        .trig(a_trig), .delay_cfg(a_delay), .width_cfg(a_width),
        .sync_out(a_sync), .busy(a_busy), .miss_cnt(a_miss)
    );

    sync_pulse_gen #(
        .NUM_CH(1), .CNT_W(8), .EDGE_DET(1), .OUT_POL(1'b1), .MISS_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .retrig_en(retrig_en),
        .trig(b_trig), .delay_cfg(b_delay), .width_cfg(b_width),
        .sync_out(b_sync), .busy(b_busy), .miss_cnt(b_miss)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input logic [7:0] d, input logic [7:0] w);
        a_delay[ch*8 +: 8] = d;
        a_width[ch*8 +: 8] = w;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        set_cfg(0, 8'd0, 8'd5);
        a_trig = 4'b0001;
        #2;
        checks++;
        if (a_sync !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL reset_sync got=%b exp=%b", a_sync, 4'b1010);
        end
        checks++;
        if (a_busy !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_busy got=%b exp=%b", a_busy, 4'b0000);
        end
        checks++;
        if (a_miss !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_miss got=%0d exp=0", a_miss);
        end
        checks++;
        if (b_sync !== 1'b0 || b_busy !== 1'b0 || b_miss !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_b got=%b/%b/%0d exp=0/0/0", b_sync, b_busy, b_miss);
        end
        a_trig = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_legacy();
        set_cfg(0, 8'd0, 8'd10);
        a_trig = 4'b0001;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (a_sync !== (4'b1010 ^ {3'b000, (k <= 10)})) begin
                errors++;
                $display("[TB] FAIL legacy_sync k=%0d got=%b", k, a_sync);
            end
            checks++;
            if (a_busy[0] !== (k >= 1 && k <= 10)) begin
                errors++;
                $display("[TB] FAIL legacy_busy k=%0d got=%b", k, a_busy[0]);
            end
            step();
            a_trig = 4'b0000;
        end
        checks++;
        if (a_miss !== 4'(exp_miss)) begin
            errors++;
            $display("[TB] FAIL legacy_miss got=%0d exp=%0d", a_miss, exp_miss);
        end
    endtask

    task automatic test_delay();
        set_cfg(0, 8'd3, 8'd2);
        a_trig = 4'b0001;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (a_sync[0] !== (k >= 3 && k <= 5)) begin
                errors++;
                $display("[TB] FAIL delay_sync k=%0d got=%b", k, a_sync[0]);
            end
            checks++;
            if (a_busy[0] !== (k >= 1 && k <= 5)) begin
                errors++;
                $display("[TB] FAIL delay_busy k=%0d got=%b", k, a_busy[0]);
            end
            step();
            a_trig = 4'b0000;
            set_cfg(0, 8'd0, 8'd9);
        end
    endtask

    task automatic test_zero_width();
        set_cfg(0, 8'd0, 8'd0);
        a_trig = 4'b0001;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            checks++;
            if (a_sync[0] !== (k == 0) || a_busy[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL zero_width k=%0d got=%b/%b", k, a_sync[0], a_busy[0]);
            end
            step();
            a_trig = 4'b0000;
        end
    endtask

    task automatic test_retrig_extend();
        retrig_en = 1'b1;
        set_cfg(0, 8'd0, 8'd4);
        a_trig = 4'b0001;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (a_sync[0] !== (k <= 7)) begin
                errors++;
                $display("[TB] FAIL extend_sync k=%0d got=%b", k, a_sync[0]);
            end
            checks++;
            if (a_busy[0] !== (k >= 1 && k <= 7)) begin
                errors++;
                $display("[TB] FAIL extend_busy k=%0d got=%b", k, a_busy[0]);
            end
            step();
            a_trig = ((k + 1) == 3) ? 4'b0001 : 4'b0000;
        end
    endtask

    task automatic test_retrig_drop();
        retrig_en = 1'b0;
        set_cfg(0, 8'd0, 8'd4);
        a_trig = 4'b0001;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (a_sync[0] !== (k <= 4)) begin
                errors++;
                $display("[TB] FAIL drop_sync k=%0d got=%b", k, a_sync[0]);
            end
            step();
            a_trig = ((k + 1) == 3) ? 4'b0001 : 4'b0000;
        end
        exp_miss = exp_miss + 1;
        checks++;
        if (a_miss !== 4'(exp_miss)) begin
            errors++;
            $display("[TB] FAIL drop_miss got=%0d exp=%0d", a_miss, exp_miss);
        end
    endtask

    task automatic test_retrig_delay();
        retrig_en = 1'b1;
        set_cfg(0, 8'd3, 8'd1);
        a_trig = 4'b0001;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (a_sync[0] !== (k >= 4 && k <= 5)) begin
                errors++;
                $display("[TB] FAIL redelay_sync k=%0d got=%b", k, a_sync[0]);
            end
            checks++;
            if (a_busy[0] !== (k >= 1 && k <= 5)) begin
                errors++;
                $display("[TB] FAIL redelay_busy k=%0d got=%b", k, a_busy[0]);
            end
            step();
            a_trig = ((k + 1) == 2) ? 4'b0001 : 4'b0000;
            if ((k + 1) == 2) set_cfg(0, 8'd2, 8'd1);
        end
    endtask

    task automatic test_multi();
        logic [3:0] exp_act;
        logic [3:0] exp_busy;
        retrig_en = 1'b0;
        for (int c = 0; c < 4; c++) set_cfg(c, 8'd0, 8'(c + 1));
        a_trig = 4'b1111;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                exp_act[c]  = (k <= c + 1);
                exp_busy[c] = (k >= 1 && k <= c + 1);
            end
            checks++;
            if (a_sync !== (exp_act ^ 4'b1010)) begin
                errors++;
                $display("[TB] FAIL multi_sync k=%0d got=%b exp=%b", k, a_sync, exp_act ^ 4'b1010);
            end
            checks++;
            if (a_busy !== exp_busy) begin
                errors++;
                $display("[TB] FAIL multi_busy k=%0d got=%b exp=%b", k, a_busy, exp_busy);
            end
            step();
            a_trig = ((k + 1) == 1) ? 4'b1111 : 4'b0000;
        end
        exp_miss = exp_miss + 1;
        checks++;
        if (a_miss !== 4'(exp_miss)) begin
            errors++;
            $display("[TB] FAIL multi_miss got=%0d exp=%0d", a_miss, exp_miss);
        end
    endtask

    task automatic test_enable();
        retrig_en = 1'b0;
        enable = 1'b0;
        set_cfg(0, 8'd0, 8'd3);
        a_trig = 4'b0001;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            checks++;
            if (a_sync !== 4'b1010 || a_busy !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL disabled k=%0d got=%b/%b exp=1010/0000", k, a_sync, a_busy);
            end
            step();
            a_trig = 4'b0000;
        end
        enable = 1'b1;
        a_trig = 4'b0001;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (a_sync[0] !== (k <= 3)) begin
                errors++;
                $display("[TB] FAIL inflight_sync k=%0d got=%b", k, a_sync[0]);
            end
            step();
            enable = ((k + 1) == 1) ? 1'b0 : 1'b1;
            a_trig = ((k + 1) == 1) ? 4'b0001 : 4'b0000;
        end
        checks++;
        if (a_miss !== 4'(exp_miss)) begin
            errors++;
            $display("[TB] FAIL enable_miss got=%0d exp=%0d", a_miss, exp_miss);
        end
    endtask

    task automatic test_edge();
        retrig_en = 1'b1;
        enable = 1'b1;
        b_delay = 8'd0;
        b_width = 8'd2;
        b_trig = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            checks++;
            if (b_sync[0] !== (k <= 2)) begin
                errors++;
                $display("[TB] FAIL edge_sync k=%0d got=%b", k, b_sync[0]);
            end
            checks++;
            if (b_busy[0] !== (k >= 1 && k <= 2)) begin
                errors++;
                $display("[TB] FAIL edge_busy k=%0d got=%b", k, b_busy[0]);
            end
            step();
            b_trig = ((k + 1) <= 29) ? 1'b1 : 1'b0;
        end
        enable = 1'b0;
        b_trig = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (b_sync[0] !== 1'b0 || b_busy[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL edge_history k=%0d got=%b/%b exp=0/0", k, b_sync[0], b_busy[0]);
            end
            step();
            if ((k + 1) == 2) enable = 1'b1;
        end
        b_trig = 1'b0;
        step();
        checks++;
        if (b_miss !== 8'd0) begin
            errors++;
            $display("[TB] FAIL edge_miss got=%0d exp=0", b_miss);
        end
    endtask

    task automatic test_max();
        enable = 1'b1;
        set_cfg(2, 8'd255, 8'd255);
        a_trig = 4'b0100;
        for (int k = 0; k <= 512; k++) begin
            @(negedge clk);
            checks++;
            if (a_sync[2] !== (k >= 255 && k <= 510)) begin
                errors++;
                $display("[TB] FAIL max_sync k=%0d got=%b", k, a_sync[2]);
            end
            checks++;
            if (a_busy[2] !== (k >= 1 && k <= 510)) begin
                errors++;
                $display("[TB] FAIL max_busy k=%0d got=%b", k, a_busy[2]);
            end
            step();
            a_trig = 4'b0000;
        end
    endtask

    task automatic test_reset_mid();
        retrig_en = 1'b1;
        enable = 1'b1;
        set_cfg(0, 8'd0, 8'd10);
        a_trig = 4'b0001;
        step();
        a_trig = 4'b0000;
        step();
        step();
        @(negedge clk);
        checks++;
        if (a_sync[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midpulse_active got=%b exp=1", a_sync[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (a_sync !== 4'b1010 || a_busy !== 4'b0000 || a_miss !== 4'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got=%b/%b/%0d exp=1010/0000/0", a_sync, a_busy, a_miss);
        end
        exp_miss = 0;
        @(negedge clk);
        rst = 1'b0;
        step();
        set_cfg(0, 8'd1, 8'd1);
        a_trig = 4'b0001;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (a_sync[0] !== (k >= 1 && k <= 2)) begin
                errors++;
                $display("[TB] FAIL post_reset_sync k=%0d got=%b", k, a_sync[0]);
            end
            checks++;
            if (a_busy[0] !== (k >= 1 && k <= 2)) begin
                errors++;
                $display("[TB] FAIL post_reset_busy k=%0d got=%b", k, a_busy[0]);
            end
            step();
            a_trig = 4'b0000;
        end
    endtask

    task automatic test_saturation();
        retrig_en = 1'b0;
        enable = 1'b1;
        set_cfg(0, 8'd0, 8'd100);
        a_trig = 4'b0001;
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            if (k == 11) begin
                checks++;
                if (a_miss !== 4'd10) begin
                    errors++;
                    $display("[TB] FAIL sat_partial got=%0d exp=10", a_miss);
                end
            end
            if (k == 17 || k == 22) begin
                checks++;
                if (a_miss !== 4'd15) begin
                    errors++;
                    $display("[TB] FAIL sat_full k=%0d got=%0d exp=15", k, a_miss);
                end
            end
            step();
            a_trig = ((k + 1) <= 21) ? 4'b0001 : 4'b0000;
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_delay();
        test_zero_width();
        test_retrig_extend();
        test_retrig_drop();
        test_retrig_delay();
        test_multi();
        test_enable();
        test_edge();
        test_max();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_pulse_gen.md
Name: sync_pulse_gen

Overview:
Multi-channel successor to the single-channel DAC sync stretcher. Each channel turns a start-of-transfer trigger into a sync pulse with run-time programmable delay and width, plus a retrigger policy and dropped-trigger accounting. It sits between the DAC/ADC start-of-transfer strobes and the external sync/gating outputs. With delay 0 and width 10 it reproduces the legacy single-channel behaviour: the pulse is high in the trigger cycle and for 10 cycles after.

Parameters:
NUM_CH, 2, number of independent trigger/sync channels (1..8)
CNT_W, 16, width of the per-channel delay and width counters
EDGE_DET, 0, 0 = trigger sampled as a level each cycle; 1 = only a 0->1 transition of trig[i] counts
OUT_POL, {NUM_CH{1'b1}}, per-channel output polarity; 1 = active-high, 0 = active-low
MISS_W, 16, width of the saturating dropped-trigger counter

Ports:
clk  in  1  block clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  global trigger-accept enable
retrig_en  in  1  1 = retrigger extends or restarts a busy channel; 0 = triggers on a busy channel are dropped
trig  in  NUM_CH  per-channel start-of-transfer strobe
delay_cfg  in  NUM_CH*CNT_W  per-channel delay D; channel i uses bits [i*CNT_W +: CNT_W]
width_cfg  in  NUM_CH*CNT_W  per-channel extra width W, packed the same way as delay_cfg
sync_out  out  NUM_CH  per-channel sync pulse, at the polarity set by OUT_POL
busy  out  NUM_CH  channel is not IDLE (registered)
miss_cnt  out  MISS_W  saturating count of cycles in which at least one trigger was dropped

Behaviour:
- Reset (async, rst=1): every channel goes to IDLE and its counters clear. sync_out[i] goes to its inactive level immediately (0 if OUT_POL[i]=1, else 1). busy=0, miss_cnt=0. The edge-detect history register clears to 0.
- Accepted trigger: the qualified trig[i] is high at cycle t, enable=1, and the channel is IDLE (or busy with retrig_en=1). D and W are sampled at t. Later changes to the config inputs do not affect a pulse in flight.
- Output timing, seen at active polarity: high for cycles t+D through t+D+W inclusive, which is W+1 cycles.
  - D=0: combinational path from trig to sync_out, so high in cycle t. D=0, W=0 gives a single cycle high at t, no state change, busy stays 0.
  - D>0: output is fully registered, with no combinational path from trig.
- Per-channel FSM: IDLE -> DELAY (D>0) or ACTIVE (D=0, W>0) -> IDLE when the width count expires.
  - busy[i] = (state != IDLE): high from t+1 through the last cycle in which the FSM is in DELAY or ACTIVE.
- Retrigger with retrig_en=1:
  - In ACTIVE at t': the width is reloaded from W sampled at t'. Output stays high with no gap through t'+W. D is not reapplied.
  - In DELAY at t': the delay restarts from t' using newly sampled D and W.
- Drop with retrig_en=0: a qualified trigger on a busy channel is ignored and the pulse in flight is unaffected.
  - miss_cnt increments by 1 in each such cycle, even if several channels drop in the same cycle.
  - miss_cnt saturates at all-ones and does not wrap.
- enable=0: triggers are ignored and not counted as misses. Pulses already in flight complete normally. The edge-detect history still updates.
- EDGE_DET=1: qualified trigger = trig[i] & ~trig_d[i]. A trig held high produces one trigger only.
- EDGE_DET=0: trig held high retriggers every cycle (if retrig_en=1), exactly as in the legacy design.
- Channels are fully independent. Simultaneous triggers on all channels are all accepted in the same cycle.
- A trigger in the final ACTIVE cycle with retrig_en=1 is treated as a retrigger, so the output has no gap.
- Counter arithmetic: unsigned CNT_W bits. D=2^CNT_W-1 and W=2^CNT_W-1 are legal and must not overflow.

Test Plan:
- Legacy match: NUM_CH=1, D=0, W=10, one-cycle trig at cycle 5 -> sync_out high cycles 5..15 (11 cycles), busy high cycles 6..15, miss_cnt=0.
- Delay: D=3, W=2, trig at cycle 20 -> sync_out low at 20..22, high at 23..25, low at 26; no combinational response at cycle 20.
- Retrigger extend: retrig_en=1, D=0, W=4, trig at 10 and again at 13 -> high 10..17 continuously; with retrig_en=0 instead -> high 10..14 and miss_cnt=1.
- Multi-channel and polarity: NUM_CH=4, OUT_POL=4'b0101, all channels triggered in the same cycle with distinct W -> each channel ends independently; channels 1 and 3 drive active-low; with retrig_en=0, a second simultaneous trigger on all four channels gives miss_cnt +1 only.
- Edge and enable: EDGE_DET=1, trig held high 30 cycles, W=2 -> exactly one 3-cycle pulse; enable=0 during a trigger -> no pulse and miss_cnt unchanged.
- Reset mid-pulse: assert rst asynchronously between clock edges while sync_out is active -> sync_out inactive and busy=0 immediately; after release, the next trigger behaves as from a clean reset. Saturation: force 2^MISS_W+5 drops -> miss_cnt = all-ones.
